gravador_jogadas: RTL and testbench

- Writer side of the game's sequence memory. Captures the player's key presses (one-hot `chaves`) into a 16x4 synchronous RAM at consecutive addresses 0..`limite`.
- The stored sequence is later read back by the comparison datapath through a registered read port. That port has the same 1-cycle latency as the sync ROM it replaces.
- Sits between the key synchronizer and the game's comparison datapath. Controlled by the top-level game FSM via `iniciar`/`pronto`.

---
 rtl/jogo_pkg.sv | 21 ++
 rtl/sync_ram_16x4.sv | 21 ++
 rtl/gravador_jogadas.sv | 88 ++++++++
 tb/tb_gravador_jogadas.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// jogo_pkg: state codes, RAM geometry and play validity shared by the writer and the checker.
package jogo_pkg;
    localparam int RAM_DEPTH = 16;
    localparam int RAM_WIDTH = 4;
    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        ESPERA   = 4'h2,
        REGISTRA = 4'h3,
        GRAVA    = 4'h4,
        SOLTA    = 4'h5,
        PROXIMA  = 4'h6,
        FIM      = 4'hA,
        TEMPO    = 4'hD,
        ERRO     = 4'hE
    } estado_t;
    // A play is valid only when exactly one key is pressed.
    function automatic logic um_quente(input logic [RAM_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - RAM_WIDTH'(1))) == '0);
    endfunction
endpackage

// File: rtl/sync_ram_16x4.sv
// sync_ram_16x4: one write port and a registered read port; reads return old data on a same-address write.
module sync_ram_16x4
    import jogo_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 we_i,
    input  logic [3:0]           wr_addr_i,
    input  logic [RAM_WIDTH-1:0] wr_data_i,
    input  logic [3:0]           rd_addr_i,
    output logic [RAM_WIDTH-1:0] rd_data_o
);
    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] rd_data_q;
    always_ff @(posedge clock)
        if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    always_ff @(posedge clock)
        if (!reset_n) rd_data_q <= '0;
        else          rd_data_q <= mem_q[rd_addr_i];
    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/gravador_jogadas.sv
// gravador_jogadas: records one-hot key plays into addresses 0..limite of a 16x4 RAM.
module gravador_jogadas
    import jogo_pkg::*;
#(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    input  logic [3:0] limite,
    input  logic [3:0] rd_endereco,
    output logic [3:0] rd_dado,
    output logic       pronto,
    output logic       erro,
    output logic       tempo_esgotado,
    output logic [3:0] db_endereco,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);
    localparam int TW = $clog2(TIMEOUT);
    estado_t       estado_q, estado_d;
    logic [3:0]    end_q, end_d, lim_q, lim_d, jog_q, jog_d;
    logic [TW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clock)
        if (!reset_n) begin
            estado_q <= INICIAL;
            end_q    <= '0;
            lim_q    <= '0;
            jog_q    <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            end_q    <= end_d;
            lim_q    <= lim_d;
            jog_q    <= jog_d;
            cnt_q    <= cnt_d;
        end
    always_comb begin
        estado_d = estado_q;
        end_d    = end_q;
        lim_d    = lim_q;
        jog_d    = jog_q;
        cnt_d    = cnt_q;
        case (estado_q)
            INICIAL, FIM, TEMPO, ERRO: estado_d = iniciar ? PREPARA : estado_q;
            PREPARA: begin
                end_d    = '0;
                cnt_d    = '0;
                lim_d    = limite;
                estado_d = ESPERA;
            end
            // A valid key outranks a timeout expiring on the same cycle.
            ESPERA: begin
                cnt_d    = cnt_q + TW'(1);
                estado_d = (chaves != '0) ? (um_quente(chaves) ? REGISTRA : ERRO)
                         : (cnt_q == TW'(TIMEOUT - 1)) ? TEMPO : ESPERA;
            end
            REGISTRA: begin
                jog_d    = chaves;
                estado_d = GRAVA;
            end
            GRAVA:   estado_d = SOLTA;
            SOLTA:   estado_d = (chaves != '0) ? SOLTA : (end_q == lim_q) ? FIM : PROXIMA;
            PROXIMA: begin
                end_d    = end_q + 4'd1;
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            default: estado_d = INICIAL;
        endcase
    end
    sync_ram_16x4 u_ram (
        .clock     (clock),
        .reset_n   (reset_n),
        .we_i      (estado_q == GRAVA),
        .wr_addr_i (end_q),
        .wr_data_i (jog_q),
        .rd_addr_i (rd_endereco),
        .rd_data_o (rd_dado)
    );
    assign pronto         = (estado_q == FIM);
    assign erro           = (estado_q == ERRO);
    assign tempo_esgotado = (estado_q == TEMPO);
    assign db_endereco    = end_q;
    assign db_jogada      = jog_q;
    assign db_estado      = estado_q;
endmodule

// File: tb/tb_gravador_jogadas.sv
// tb_gravador_jogadas: directed vectors with hand-computed expectations for the play recorder.
module tb_gravador_jogadas;
    logic       clock = 1'b0;
    logic       reset_n, iniciar;
    logic [3:0] chaves, limite, rd_endereco;
    logic [3:0] rd_dado, db_endereco, db_jogada, db_estado;
    logic       pronto, erro, tempo_esgotado;
    int         checks = 0;
    int         failures = 0;

    gravador_jogadas #(.TIMEOUT(10)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .iniciar        (iniciar),
        .chaves         (chaves),
        .limite         (limite),
        .rd_endereco    (rd_endereco),
        .rd_dado        (rd_dado),
        .pronto         (pronto),
        .erro           (erro),
        .tempo_esgotado (tempo_esgotado),
        .db_endereco    (db_endereco),
        .db_jogada      (db_jogada),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    task automatic conferir(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aguardar(input logic [3:0] est, input int max);
        int n = 0;
        while (db_estado !== est && n < max) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== est) conferir("wait_state", {28'd0, db_estado}, {28'd0, est});
    endtask

    task automatic comecar(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        conferir("prepara", {28'd0, db_estado}, 32'h1);
    endtask

    task automatic jogar(input logic [3:0] k);
        aguardar(4'h2, 50);
        chaves = k;
        repeat (3) @(negedge clock);
        chaves = 4'h0;
        repeat (2) @(negedge clock);
    endtask

    task automatic ler(input logic [3:0] a, input logic [3:0] exp);
        rd_endereco = a;
        @(negedge clock);
        conferir($sformatf("ram[%0d]", a), {28'd0, rd_dado}, {28'd0, exp});
    endtask

    initial begin
        logic [3:0] seq1 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
        logic [3:0] seq5 [6] = '{4'h2, 4'h4, 4'h1, 4'h8, 4'h2, 4'h4};
        reset_n = 1'b0; iniciar = 1'b0; chaves = '0; limite = '0; rd_endereco = '0;
        repeat (3) @(negedge clock);
        conferir("rst_estado", {28'd0, db_estado}, 32'h0);
        conferir("rst_rd_dado", {28'd0, rd_dado}, 32'h0);
        conferir("rst_flags", {29'd0, pronto, erro, tempo_esgotado}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        conferir("idle_estado", {28'd0, db_estado}, 32'h0);

        // 1: four plays into addresses 0..3
        comecar(4'h3);
        foreach (seq1[i]) jogar(seq1[i]);
        conferir("t1_pronto", {31'd0, pronto}, 32'h1);
        conferir("t1_estado", {28'd0, db_estado}, 32'hA);
        conferir("t1_jogada", {28'd0, db_jogada}, 32'h8);
        foreach (seq1[i]) ler(4'(i), seq1[i]);

        // 2: limite=0 records a single play
        comecar(4'h0);
        jogar(4'h4);
        conferir("t2_pronto", {31'd0, pronto}, 32'h1);
        conferir("t2_endereco", {28'd0, db_endereco}, 32'h0);
        ler(4'h0, 4'h4);
        ler(4'h1, 4'h2);

        // 3: two keys at address 2 -> ERRO, no write
        comecar(4'h3);
        jogar(4'h1);
        jogar(4'h2);
        aguardar(4'h2, 50);
        conferir("t3_endereco", {28'd0, db_endereco}, 32'h2);
        chaves = 4'b0110;
        @(negedge clock);
        chaves = 4'h0;
        conferir("t3_estado", {28'd0, db_estado}, 32'hE);
        conferir("t3_erro", {31'd0, erro}, 32'h1);
        ler(4'h2, 4'h4);
        comecar(4'h5);
        conferir("t3_erro_limpo", {31'd0, erro}, 32'h0);

        // 5: reset while held in SOLTA at address 5
        for (int i = 0; i < 5; i++) jogar(seq5[i]);
        aguardar(4'h2, 50);
        chaves = seq5[5];
        repeat (3) @(negedge clock);
        conferir("t5_solta", {28'd0, db_estado}, 32'h5);
        conferir("t5_endereco5", {28'd0, db_endereco}, 32'h5);
        reset_n = 1'b0;
        @(negedge clock);
        conferir("t5_estado", {28'd0, db_estado}, 32'h0);
        conferir("t5_flags", {29'd0, pronto, erro, tempo_esgotado}, 32'h0);
        conferir("t5_endereco", {28'd0, db_endereco}, 32'h0);
        reset_n = 1'b1;
        chaves  = 4'h0;
        foreach (seq5[i]) ler(4'(i), seq5[i]);

        // 6: same-address read during the write returns old data first
        comecar(4'h2);
        jogar(4'h4);
        jogar(4'h2);
        rd_endereco = 4'h2;
        aguardar(4'h2, 50);
        chaves = 4'h8;
        repeat (3) @(negedge clock);
        chaves = 4'h0;
        conferir("t6_antigo", {28'd0, rd_dado}, 32'h1);
        @(negedge clock);
        conferir("t6_novo", {28'd0, rd_dado}, 32'h8);
        conferir("t6_pronto", {31'd0, pronto}, 32'h1);

        // 4: timeout after 10 ESPERA cycles; key on the last cycle wins
        comecar(4'h0);
        aguardar(4'h2, 5);
        repeat (9) @(negedge clock);
        conferir("t4_ainda_espera", {28'd0, db_estado}, 32'h2);
        @(negedge clock);
        conferir("t4_tempo", {28'd0, db_estado}, 32'hD);
        conferir("t4_tempo_esgotado", {31'd0, tempo_esgotado}, 32'h1);
        comecar(4'h0);
        conferir("t4_tempo_limpo", {31'd0, tempo_esgotado}, 32'h0);
        aguardar(4'h2, 5);
        repeat (9) @(negedge clock);
        chaves = 4'h1;
        @(negedge clock);
        conferir("t4_registra", {28'd0, db_estado}, 32'h3);
        repeat (2) @(negedge clock);
        chaves = 4'h0;
        repeat (2) @(negedge clock);
        conferir("t4_pronto", {31'd0, pronto}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
